usrt_rx_ctrl: RTL and testbench

Receive-side frame controller for the USRT. Sits on the parallel-clock side of the receive shift register. It captures each completed 11-bit frame, checks the start, stop and parity bits, and buffers accepted bytes in a small FIFO. The host drains the FIFO through a valid/ready handshake, and sticky error and overrun status are reported alongside.

---
 rtl/usrt_rx_ctrl_pkg.sv | 34 +++
 rtl/usrt_rx_fifo.sv | 81 ++++++++
 rtl/usrt_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_usrt_rx_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_rx_ctrl_pkg.sv
// usrt_rx_ctrl_pkg
// Shared definitions for the USRT receive controller: frame bit positions,
// FIFO entry width, FSM state encoding and the frame check helpers.
// No ports (package).
package usrt_rx_ctrl_pkg;

    localparam int FRAME_W     = 11;
    localparam int FR_START    = 0;
    localparam int FR_DATA_LSB = 1;
    localparam int FR_DATA_MSB = 8;
    localparam int FR_PAR      = 9;
    localparam int FR_STOP     = 10;

    // FIFO entry: {parity error, data byte}
    localparam int ENTRY_W = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PUSH  = 2'd2
    } rx_state_t;

    // Framing is bad when the start bit is not 0 or the stop bit is not 1.
    function automatic logic frame_bad(input logic [FRAME_W-1:0] frame);
        return frame[FR_START] | ~frame[FR_STOP];
    endfunction

    // Parity over data bits plus the parity bit must equal the odd flag.
    function automatic logic parity_bad(input logic [FRAME_W-1:0] frame,
                                        input logic odd);
        return (^frame[FR_PAR:FR_DATA_LSB]) != odd;
    endfunction

endpackage

// File: rtl/usrt_rx_fifo.sv
// usrt_rx_fifo
// Synchronous FIFO holding received entries. Supports push and pop in the
// same cycle; a push into a full FIFO succeeds when a pop frees the slot in
// that same cycle. The head entry is held in a register so it is stable for
// the host while nothing is popped.
// Ports:
//   i_Pclk, i_Rst      clock, async active-high reset
//   i_Push, i_Wr_Data  write request and entry
//   i_Pop              read request (ignored when empty)
//   o_Rd_Data          registered head entry
//   o_Full, o_Empty    occupancy flags
//   o_Count            occupancy, 0..DEPTH
module usrt_rx_fifo
    import usrt_rx_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     i_Pclk,
    input  logic                     i_Rst,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_Wr_Data,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_Rd_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    assign o_Empty    = (count == '0);
    assign o_Full     = (count == CNT_W'(DEPTH));
    assign o_Count    = count;
    assign rd_en      = i_Pop & ~o_Empty;
    assign wr_en      = i_Push & (~o_Full | rd_en);
    assign rd_ptr_nxt = rd_en ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_Rd_Data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= i_Wr_Data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Head register tracks the entry at the next read pointer. When the
            // write lands on that slot (FIFO empty after this cycle's pop),
            // bypass the memory so the new entry appears right away.
            if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
                o_Rd_Data <= i_Wr_Data;
            end else begin
                o_Rd_Data <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/usrt_rx_ctrl.sv
// usrt_rx_ctrl
// Receive-side frame controller. Latches each completed 11-bit frame, checks
// start/stop/parity, and queues accepted bytes (with their parity error flag)
// in a FIFO drained by the host over valid/ready. Sticky frame-error and
// overrun flags are cleared by i_Err_Clr; a coincident set wins.
// Ports:
//   i_Pclk, i_Rst                 clock, async active-high reset
//   i_Frame_Done, i_Frame         frame-complete pulse and captured frame
//   i_Enable                      receiver enable
//   o_Rx_Data, o_Rx_PErr          head byte and its parity error flag
//   o_Rx_Valid, i_Rx_Ready        host handshake
//   o_Frame_Err, o_Overrun        sticky status
//   i_Err_Clr                     clear pulse for the sticky flags
//   o_Count                       FIFO occupancy
//
// state   | meaning
// S_IDLE  | waiting for an enabled frame-done pulse
// S_CHECK | frame latched; computing framing and parity flags
// S_PUSH  | write to FIFO, or flag frame error / overrun
module usrt_rx_ctrl
    import usrt_rx_ctrl_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                   i_Pclk,
    input  logic                   i_Rst,
    input  logic                   i_Frame_Done,
    input  logic [FRAME_W-1:0]     i_Frame,
    input  logic                   i_Enable,
    output logic [7:0]             o_Rx_Data,
    output logic                   o_Rx_PErr,
    output logic                   o_Rx_Valid,
    input  logic                   i_Rx_Ready,
    output logic                   o_Frame_Err,
    output logic                   o_Overrun,
    input  logic                   i_Err_Clr,
    output logic [$clog2(DEPTH):0] o_Count
);

    rx_state_t          state;
    logic [FRAME_W-1:0] r_frame;
    logic               r_ferr;
    logic               r_perr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic               pop;
    logic               push;
    logic               push_blocked;
    logic               new_frame;

    assign new_frame    = i_Frame_Done & i_Enable;
    assign pop          = ~fifo_empty & i_Rx_Ready;
    assign push         = (state == S_PUSH) & ~r_ferr;
    // A pop in the write cycle frees a slot, so only a full FIFO without a
    // pop blocks the write.
    assign push_blocked = fifo_full & ~pop;

    assign o_Rx_Valid = ~fifo_empty;
    assign o_Rx_Data  = head[7:0];
    assign o_Rx_PErr  = head[8];

    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            r_frame     <= '0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            // Clear first so a set later in this block takes precedence.
            if (i_Err_Clr) begin
                o_Frame_Err <= 1'b0;
                o_Overrun   <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (new_frame) begin
                        r_frame <= i_Frame;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_ferr <= frame_bad(r_frame);
                    r_perr <= PARITY_EN & parity_bad(r_frame, PARITY_ODD);
                    state  <= S_PUSH;
                    if (new_frame) begin
                        o_Overrun <= 1'b1;
                    end
                end
                S_PUSH: begin
                    if (r_ferr) begin
                        o_Frame_Err <= 1'b1;
                    end else if (push_blocked) begin
                        o_Overrun <= 1'b1;
                    end
                    if (new_frame) begin
                        o_Overrun <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    usrt_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_Pclk    (i_Pclk),
        .i_Rst     (i_Rst),
        .i_Push    (push),
        .i_Wr_Data ({r_perr, r_frame[FR_DATA_MSB:FR_DATA_LSB]}),
        .i_Pop     (pop),
        .o_Rd_Data (head),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty),
        .o_Count   (o_Count)
    );

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// tb_usrt_rx_ctrl
// Self-checking bench for usrt_rx_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model. A second
// instance with parity checking disabled shares the stimulus.
module tb_usrt_rx_ctrl;

    localparam int DEPTH = 4;
    localparam bit ODD   = 1'b0;

    logic        i_Pclk = 1'b0;
    logic        i_Rst;
    logic        i_Frame_Done;
    logic [10:0] i_Frame;
    logic        i_Enable;
    logic        i_Rx_Ready;
    logic        i_Err_Clr;

    logic [7:0]  rx_data,  np_data;
    logic        rx_perr,  np_perr;
    logic        rx_valid, np_valid;
    logic        frame_err, np_ferr;
    logic        overrun,  np_ovr;
    logic [2:0]  count,    np_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [8:0]  mq[$];
    int          stage;
    logic [10:0] pend;
    logic        m_ferr, m_ovr;

    always #5 i_Pclk = ~i_Pclk;

    usrt_rx_ctrl #(.DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(ODD)) dut (
        .i_Pclk(i_Pclk), .i_Rst(i_Rst), .i_Frame_Done(i_Frame_Done), .i_Frame(i_Frame),
        .i_Enable(i_Enable), .o_Rx_Data(rx_data), .o_Rx_PErr(rx_perr), .o_Rx_Valid(rx_valid),
        .i_Rx_Ready(i_Rx_Ready), .o_Frame_Err(frame_err), .o_Overrun(overrun),
        .i_Err_Clr(i_Err_Clr), .o_Count(count)
    );

    usrt_rx_ctrl #(.DEPTH(DEPTH), .PARITY_EN(1'b0), .PARITY_ODD(ODD)) dut_np (
        .i_Pclk(i_Pclk), .i_Rst(i_Rst), .i_Frame_Done(i_Frame_Done), .i_Frame(i_Frame),
        .i_Enable(i_Enable), .o_Rx_Data(np_data), .o_Rx_PErr(np_perr), .o_Rx_Valid(np_valid),
        .i_Rx_Ready(i_Rx_Ready), .o_Frame_Err(np_ferr), .o_Overrun(np_ovr),
        .i_Err_Clr(i_Err_Clr), .o_Count(np_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit par_good,
                                             input bit start, input bit stop);
        logic p;
        p = (^d) ^ ODD;
        if (!par_good) p = ~p;
        return {stop, p, d, start};
    endfunction

    task automatic model_reset();
        mq.delete();
        stage  = 0;
        pend   = '0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One rising edge of the reference model. Frame accepted at edge n is
    // checked and queued at edge n+2; enabled frames arriving meanwhile are lost.
    task automatic model_step(input logic d, input logic [10:0] f, input logic en,
                              input logic rdy, input logic clr);
        bit set_f = 0;
        bit set_o = 0;
        bit popq;
        int old_stage;
        int size_before;
        bit perr;
        old_stage   = stage;
        size_before = mq.size();
        popq        = (size_before > 0) && rdy;
        if (popq) void'(mq.pop_front());
        if (old_stage == 2) begin
            perr = (($countones(pend[9:1]) % 2) != int'(ODD));
            if (pend[0] != 1'b0 || pend[10] != 1'b1) set_f = 1;
            else if (size_before == DEPTH && !popq) set_o = 1;
            else mq.push_back({perr, pend[8:1]});
            stage = 0;
        end else if (old_stage == 1) begin
            stage = 2;
        end else if (d && en) begin
            pend  = f;
            stage = 1;
        end
        if (old_stage != 0 && d && en) set_o = 1;
        if (clr) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (set_f) m_ferr = 1'b1;
        if (set_o) m_ovr  = 1'b1;
    endtask

    task automatic compare_all();
        chk("valid",     32'(rx_valid),  32'(mq.size() > 0));
        chk("count",     32'(count),     32'(mq.size()));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("np_valid",  32'(np_valid),  32'(mq.size() > 0));
        chk("np_count",  32'(np_count),  32'(mq.size()));
        chk("np_ovr",    32'(np_ovr),    32'(m_ovr));
        if (mq.size() > 0) begin
            chk("data",    32'(rx_data), 32'(mq[0][7:0]));
            chk("perr",    32'(rx_perr), 32'(mq[0][8]));
            chk("np_data", 32'(np_data), 32'(mq[0][7:0]));
            chk("np_perr", 32'(np_perr), 32'd0);
        end
    endtask

    task automatic cyc(input logic d, input logic [10:0] f, input logic en,
                       input logic rdy, input logic clr);
        i_Frame_Done = d;
        i_Frame      = f;
        i_Enable     = en;
        i_Rx_Ready   = rdy;
        i_Err_Clr    = clr;
        @(posedge i_Pclk);
        model_step(d, f, en, rdy, clr);
        @(negedge i_Pclk);
        compare_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 11'd0, 1'b1, rdy, 1'b0);
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, mk_frame(d, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        i_Rst = 1'b1;
        i_Frame_Done = 1'b0; i_Frame = '0; i_Enable = 1'b0;
        i_Rx_Ready = 1'b0; i_Err_Clr = 1'b0;
        model_reset();
        @(negedge i_Pclk);
        @(negedge i_Pclk);
        chk("rst_valid", 32'(rx_valid),  32'd0);
        chk("rst_data",  32'(rx_data),   32'd0);
        chk("rst_perr",  32'(rx_perr),   32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
        chk("rst_count", 32'(count),     32'd0);
        i_Rst = 1'b0;

        // good frame 0xA5
        fr = 11'b1_0_10100101_0;
        cyc(1'b1, fr, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("a5_valid", 32'(rx_valid), 32'd1);
        chk("a5_data",  32'(rx_data),  32'hA5);
        chk("a5_perr",  32'(rx_perr),  32'd0);
        idle(1, 1'b1);
        chk("a5_popped", 32'(rx_valid), 32'd0);

        // parity error 0x01 with parity bit 0
        fr = {1'b1, 1'b0, 8'h01, 1'b0};
        cyc(1'b1, fr, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("pe_valid",   32'(rx_valid),  32'd1);
        chk("pe_perr",    32'(rx_perr),   32'd1);
        chk("pe_np_perr", 32'(np_perr),   32'd0);
        chk("pe_ferr",    32'(frame_err), 32'd0);
        chk("pe_ovr",     32'(overrun),   32'd0);
        idle(1, 1'b1);

        // stop bit 0
        cyc(1'b1, mk_frame(8'h3C, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("fe_valid", 32'(rx_valid),  32'd0);
        chk("fe_flag",  32'(frame_err), 32'd1);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b1);
        chk("fe_clr",   32'(frame_err), 32'd0);

        // overflow with five frames, ready low
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        chk("ovf_count", 32'(count),   32'd4);
        chk("ovf_flag",  32'(overrun), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 32'(rx_data), 32'h10 + 32'(i));
            idle(1, 1'b1);
        end
        chk("ovf_drained", 32'(rx_valid), 32'd0);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b1);

        // full FIFO with pop in the write cycle
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
        cyc(1'b1, mk_frame(8'h20, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        chk("fullpop_count", 32'(count),   32'd4);
        chk("fullpop_ovr",   32'(overrun), 32'd0);
        idle(4, 1'b1);

        // back-to-back done pulses
        cyc(1'b1, mk_frame(8'h40, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, mk_frame(8'h41, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("b2b_ovr",   32'(overrun), 32'd1);
        chk("b2b_count", 32'(count),   32'd1);
        chk("b2b_data",  32'(rx_data), 32'h40);
        idle(1, 1'b1);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b1);

        // async reset while a frame is being checked
        send(8'h50);
        send(8'h51);
        cyc(1'b1, mk_frame(8'h52, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        i_Frame_Done = 1'b0;
        i_Rst = 1'b1;
        #1;
        chk("arst_valid", 32'(rx_valid),  32'd0);
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_data",  32'(rx_data),   32'd0);
        chk("arst_perr",  32'(rx_perr),   32'd0);
        chk("arst_ferr",  32'(frame_err), 32'd0);
        chk("arst_ovr",   32'(overrun),   32'd0);
        model_reset();
        #1;
        i_Rst = 1'b0;
        idle(3, 1'b0);
        chk("arst_idle", 32'(rx_valid), 32'd0);
        send(8'h53);
        chk("arst_next_valid", 32'(rx_valid), 32'd1);
        chk("arst_next_data",  32'(rx_data),  32'h53);
        chk("arst_next_count", 32'(count),    32'd1);
        idle(1, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       d, en, rdy, clr;
            logic [7:0] dat;
            d   = ($urandom_range(0, 3) == 0);
            dat = 8'($urandom);
            fr  = mk_frame(dat, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 15) == 0, $urandom_range(0, 15) != 0);
            en  = ($urandom_range(0, 15) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 31) == 0);
            cyc(d, fr, en, rdy, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
